// File: rtl/embedded_system_nios2_qsys_0_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer built around one registered 16x16 multiplier.
// Accumulates up to four partial products, then applies signed high-word correction.
module embedded_system_nios2_qsys_0_mul_seq #(
    parameter bit          ALLOW_MULX = 1'b1,
    parameter logic [31:0] RESULT_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] mul_src1,
    input  logic [31:0] mul_src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIXUP,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    state_t      state_reg;
    logic [31:0] src1_reg;
    logic [31:0] src2_reg;
    logic [1:0]  op_reg;
    logic [1:0]  idx_reg;
    logic [63:0] acc_reg;
    logic [31:0] prod_reg;
    logic [5:0]  prod_shift_reg;

    logic [1:0]  op_eff;
    logic [1:0]  last_idx;
    logic [15:0] a_half [2];
    logic [15:0] b_half [2];
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [5:0]  issue_shift;
    logic [63:0] pp_aligned;
    logic [31:0] corr_src1;
    logic [31:0] corr_src2;
    logic [31:0] result_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign a_half[gi] = src1_reg[16*gi +: 16];
            assign b_half[gi] = src2_reg[16*gi +: 16];
        end
    endgenerate

    assign op_eff   = ALLOW_MULX ? op : OP_MUL;
    assign last_idx = (op_reg == OP_MUL) ? 2'd2 : 2'd3;

    // Issue index bit 0 picks the src1 half, bit 1 the src2 half: order aL*bL, aH*bL, aL*bH, aH*bH.
    assign mul_a       = a_half[idx_reg[0]];
    assign mul_b       = b_half[idx_reg[1]];
    assign issue_shift = {({1'b0, idx_reg[0]} + {1'b0, idx_reg[1]}), 4'b0000};
    assign pp_aligned  = {32'b0, prod_reg} << prod_shift_reg;

    // Two's-complement high word from the unsigned product by subtracting the opposite operand.
    assign corr_src1 = (((op_reg == OP_MULXSU) || (op_reg == OP_MULXSS)) && src1_reg[31])
                       ? src2_reg : 32'h0;
    assign corr_src2 = ((op_reg == OP_MULXSS) && src2_reg[31]) ? src1_reg : 32'h0;
    assign result_next = (op_reg == OP_MUL) ? acc_reg[31:0]
                                            : acc_reg[63:32] - corr_src1 - corr_src2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_reg <= 32'h0;
        end else begin
            prod_reg <= {16'h0, mul_a} * {16'h0, mul_b};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= RESULT_RST;
            acc_reg        <= 64'h0;
            src1_reg       <= 32'h0;
            src2_reg       <= 32'h0;
            op_reg         <= OP_MUL;
            idx_reg        <= 2'd0;
            prod_shift_reg <= 6'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src1_reg  <= mul_src1;
                        src2_reg  <= mul_src2;
                        op_reg    <= op_eff;
                        acc_reg   <= 64'h0;
                        idx_reg   <= 2'd0;
                        busy      <= 1'b1;
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // prod_reg only holds a valid product from the second issue cycle on.
                    if (idx_reg != 2'd0) begin
                        acc_reg <= acc_reg + pp_aligned;
                    end
                    prod_shift_reg <= issue_shift;
                    if (idx_reg == last_idx) begin
                        state_reg <= S_DRAIN;
                    end else begin
                        idx_reg <= idx_reg + 2'd1;
                    end
                end
                S_DRAIN: begin
                    acc_reg   <= acc_reg + pp_aligned;
                    state_reg <= S_FIXUP;
                end
                S_FIXUP: begin
                    result    <= result_next;
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_embedded_system_nios2_qsys_0_mul_seq.sv
// Bench for the multiply sequencer: arithmetic reference model with cycle countdown,
// per-cycle compare of busy/done/result, and directed vectors with literal results.
module tb_embedded_system_nios2_qsys_0_mul_seq;

    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    embedded_system_nios2_qsys_0_mul_seq #(
        .ALLOW_MULX(1'b1),
        .RESULT_RST(RST_VAL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .mul_src1(src1),
        .mul_src2(src2),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the 64-bit product of suitably extended operands, low or high word.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = o[1] ? {{32{a[31]}}, a} : {32'h0, a};
        xb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = xa * xb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Model: countdown of remaining busy cycles; done on the last one, result shown from then on.
    int          m_cnt;
    logic [31:0] m_pending;
    logic [31:0] m_result;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt    <= 0;
            m_result <= RST_VAL;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt     <= (op == 2'b00) ? 6 : 7;
                m_pending <= ref_mul(op, src1, src2);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_result <= m_pending;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc busy", {31'b0, busy}, {31'b0, m_cnt != 0});
            check("cyc done", {31'b0, done}, {31'b0, m_cnt == 1});
            check("cyc result", result, m_result);
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        int busy_n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        n = 0;
        busy_n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                src1  = $urandom;
                src2  = $urandom;
                op    = 2'($urandom_range(3));
            end
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
        $display("txn %s op=%0d a=%h b=%h result=%h latency=%0d", name, o, a, b, result, n);
    endtask

    initial begin
        int dn;
        int first_done;
        int second_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src1  = 32'h0;
        src2  = 32'h0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset result", result, RST_VAL);
        reset = 1'b0;

        run_op("MUL", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 6);
        run_op("MULXUU", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7);
        run_op("MULXSS", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7);
        run_op("MULXSU", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7);
        run_op("MULXSS min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7);
        run_op("MUL b2b", 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 6);
        run_op("MUL wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 6);

        // start held high with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        src1  = 32'h1234_5678;
        src2  = 32'h9ABC_DEF0;
        dn = 0;
        first_done = 0;
        second_done = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            src1 = $urandom;
            src2 = $urandom;
            if (done) begin
                dn++;
                if (first_done == 0) first_done = i;
                else second_done = i;
            end
        end
        start = 1'b0;
        check("held start done count", 32'(dn), 32'd2);
        check("held start first done", 32'(first_done), 32'd7);
        check("held start second done", 32'(second_done), 32'd15);
        $display("txn held-start MULXUU dones=%0d at %0d,%0d", dn, first_done, second_done);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("held start idle", {31'b0, busy}, 32'h0);

        // reset in the middle of a MULXSS issue phase
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        src1  = 32'h8000_0001;
        src2  = 32'h8000_0003;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midop reset busy", {31'b0, busy}, 32'h0);
        check("midop reset done", {31'b0, done}, 32'h0);
        check("midop reset result", result, RST_VAL);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("no done after reset", 32'(dn), 32'd0);
        $display("txn reset-abort MULXSS dones=%0d result=%h", dn, result);

        run_op("MULXSS post-reset", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 7);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/embedded_system_nios2_qsys_0_mul_seq.md
Name: embedded_system_nios2_qsys_0_mul_seq

Overview:
- Multi-cycle multiply sequencer for the Nios II custom datapath.
- Sits directly downstream of the register-read stage and computes MUL, MULXUU, MULXSU and MULXSS results.
- Uses one internal 16x16 unsigned multiplier with a registered output, giving 1-cycle latency, the same timing as the existing mult cell.
- Issues up to four partial products, accumulates them into a 64-bit register, applies signed correction, and returns a 32-bit result under a start/done handshake.

Parameters:
- ALLOW_MULX, 1, 1 = all four ops supported; 0 = op[1:0] ignored and every operation executes as MUL.
- RESULT_RST, 32'h0, value loaded into result on reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS (high words).
- mul_src1  in  32  operand A.
- mul_src2  in  32  operand B.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  product word; held until the next accepted start.

Behaviour:
- Reset (async, active-high): state = IDLE, busy = 0, done = 0, result = RESULT_RST, accumulator = 0, multiplier output register = 0. Reset mid-operation abandons the operation; no done pulse is produced.
- Accept: in IDLE with start = 1 at edge T, latch src1, src2 and op, clear the accumulator, and go to ISSUE. start is ignored while busy, including the DONE cycle.
- Partial-product order (aL/aH = src1[15:0]/[31:16], likewise for b):
  - pp0 = aL*bL, shift 0
  - pp1 = aH*bL, shift 16
  - pp2 = aL*bH, shift 16
  - pp3 = aH*bH, shift 32
- Issue count k: MUL issues pp0..pp2 (k = 3); MULX* issues pp0..pp3 (k = 4).
- States:
  - ISSUE: cycles T+1..T+k, one pp per cycle. From the second issue cycle on, the accumulator adds the previous cycle's registered product, shifted.
  - DRAIN: T+k+1, accumulates the last pp.
  - FIXUP: T+k+2.
    - MUL: result = acc[31:0].
    - MULXUU: result = acc[63:32].
    - MULXSU: result = acc[63:32] - (src1[31] ? src2 : 0).
    - MULXSS: result = acc[63:32] - (src1[31] ? src2 : 0) - (src2[31] ? src1 : 0).
    - All arithmetic is modulo 2^32.
  - DONE: T+k+3; done = 1 for exactly one cycle, then IDLE.
- Latency (accepting edge to done-high cycle): MUL 6 cycles, MULX* 7 cycles. Back-to-back throughput: a new start is accepted on the cycle after DONE.
- busy rises at T+1 and falls after the DONE cycle.
- result updates only at the FIXUP-to-DONE edge and is stable while done is high and afterwards.
- Accumulator is 64-bit unsigned; carries beyond bit 63 are discarded.
- Operand inputs may change freely after the accepting edge.

Test Plan:
- MUL: src1 = 32'h0001_0003, src2 = 32'h0002_0005, op = 00 -> done 6 cycles after the accepting edge, result = 32'h000B_000F, busy high for exactly 6 cycles.
- MULXUU: src1 = src2 = 32'hFFFF_FFFF -> result = 32'hFFFF_FFFE at 7 cycles.
- Signed ops with src1 = src2 = 32'hFFFF_FFFF:
  - MULXSS -> result = 32'h0000_0000.
  - MULXSU -> result = 32'hFFFF_FFFF.
- MULXSS: src1 = src2 = 32'h8000_0000 -> result = 32'h4000_0000. Then drive start on the cycle after done with op = 00, src1 = 7, src2 = 6 -> accepted, result = 32'h0000_002A.
- start held high throughout a MULXUU op with changing operands -> exactly one done, result unaffected by operand changes, second op accepted only after DONE.
- Assert reset during ISSUE of a MULXSS -> busy, done and result go immediately to 0 / 0 / RESULT_RST, no done pulse follows, and the next start behaves normally.
